// File: rtl/ripple_carry_seq_if.sv
// Request/result bundle between a requesting datapath and the nibble-serial adder.
interface ripple_carry_seq_if #(
   parameter int NIBBLES = 4
);
   localparam int W = 4 * NIBBLES;

   logic         start_i;
   logic [W-1:0] a_i;
   logic [W-1:0] b_i;
   logic         c_i;
   logic         busy_o;
   logic         done_o;
   logic [W-1:0] s_o;
   logic         c_o;

   modport master (
      output start_i, a_i, b_i, c_i,
      input  busy_o, done_o, s_o, c_o
   );

   modport slave (
      input  start_i, a_i, b_i, c_i,
      output busy_o, done_o, s_o, c_o
   );
endinterface

// File: rtl/ripple_carry_seq.sv
// Nibble-serial wide adder: one shared 4-bit ripple-carry adder driven
// once per clock, least-significant nibble first, carry held between nibbles.

// 4-bit combinational ripple-carry adder.
module ripple_carry (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       c_i,
   output logic [3:0] s_o,
   output logic       c_o
);
   logic [4:0] cy;

   assign cy[0] = c_i;

   for (genvar i = 0; i < 4; i++) begin : g_fa
      assign s_o[i]    = a_i[i] ^ b_i[i] ^ cy[i];
      assign cy[i+1]   = (a_i[i] & b_i[i]) | (cy[i] & (a_i[i] ^ b_i[i]));
   end

   assign c_o = cy[4];
endmodule

module ripple_carry_seq #(
   parameter int NIBBLES = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   ripple_carry_seq_if.slave bus
);
   localparam int W  = 4 * NIBBLES;
   localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_q;
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic          cy_q;
   logic [CW-1:0] cnt_q;
   logic [W-1:0]  s_q;
   logic [W-1:0]  s_d;
   logic          co_q;
   logic          busy_q;
   logic          done_q;

   logic [3:0]    a_nib;
   logic [3:0]    b_nib;
   logic [3:0]    sum_nib;
   logic          sum_co;

   // Select the operand nibbles addressed by the nibble counter.
   always_comb begin
      a_nib = 4'd0;
      b_nib = 4'd0;
      for (int k = 0; k < NIBBLES; k++) begin
         if (cnt_q == CW'(k)) begin
            a_nib = a_q[4*k +: 4];
            b_nib = b_q[4*k +: 4];
         end
      end
   end

   ripple_carry u_adder (
      .a_i (a_nib),
      .b_i (b_nib),
      .c_i (cy_q),
      .s_o (sum_nib),
      .c_o (sum_co)
   );

   // Merge the freshly computed sum nibble into the result register image.
   always_comb begin
      s_d = s_q;
      for (int k = 0; k < NIBBLES; k++) begin
         if (cnt_q == CW'(k)) begin
            s_d[4*k +: 4] = sum_nib;
         end
      end
   end

   // Control FSM with registered busy/done flags that mirror the state.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
         cy_q    <= 1'b0;
         s_q     <= '0;
         co_q    <= 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               s_q  <= s_d;
               cy_q <= sum_co;
               if (cnt_q == LAST) begin
                  co_q    <= sum_co;
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               // IDLE and DONE both accept a new request; DONE falls back to IDLE.
               done_q <= 1'b0;
               if (bus.start_i) begin
                  a_q     <= bus.a_i;
                  b_q     <= bus.b_i;
                  cy_q    <= bus.c_i;
                  cnt_q   <= '0;
                  s_q     <= '0;
                  co_q    <= 1'b0;
                  state_q <= RUN;
                  busy_q  <= 1'b1;
               end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
         endcase
      end
   end

   assign bus.busy_o = busy_q;
   assign bus.done_o = done_q;
   assign bus.s_o    = s_q;
   assign bus.c_o    = co_q;
endmodule

// File: tb/tb_ripple_carry_seq.sv
// Bench for ripple_carry_seq: a 4-nibble and a 1-nibble instance.
module tb_ripple_carry_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;

   int n_total = 0;
   int n_pass  = 0;

   ripple_carry_seq_if #(.NIBBLES(4)) bus4 ();
   ripple_carry_seq_if #(.NIBBLES(1)) bus1 ();

   ripple_carry_seq #(.NIBBLES(4)) dut4 (.clk_i(clk), .rst_i(rst), .bus(bus4.slave));
   ripple_carry_seq #(.NIBBLES(1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1.slave));

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        c;
      logic [15:0] s;
      logic        co;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Wait for done on the 4-nibble instance, counting busy cycles; call just after E0.
   task automatic wait_done(output int busy_cnt, output int lat);
      busy_cnt = 0;
      lat      = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (bus4.done_o === 1'b1) begin
            lat = i - 1;
            break;
         end
         if (bus4.busy_o === 1'b1) busy_cnt++;
      end
   endtask

   task automatic do_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic [15:0] es, input logic eco);
      int bc, lat;
      @(posedge clk); #1;
      bus4.start_i = 1'b1;
      bus4.a_i = a;
      bus4.b_i = b;
      bus4.c_i = c;
      @(posedge clk); #1;
      bus4.start_i = 1'b0;
      bus4.a_i = ~a;
      bus4.b_i = ~b;
      bus4.c_i = ~c;
      wait_done(bc, lat);
      chk({name, " busy_cycles"}, 64'(bc), 64'd4);
      chk({name, " latency"}, 64'(lat), 64'd4);
      chk({name, " s_o"}, 64'(bus4.s_o), 64'(es));
      chk({name, " c_o"}, 64'(bus4.c_o), 64'(eco));
      @(negedge clk);
      chk({name, " done_pulse_end"}, 64'(bus4.done_o), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int bc, lat, ndone;

      vecs[0] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
      vecs[2] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
      vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
      vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
      vecs[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
      vecs[6] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0};
      vecs[7] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};

      bus4.start_i = 1'b0; bus4.a_i = '0; bus4.b_i = '0; bus4.c_i = 1'b0;
      bus1.start_i = 1'b0; bus1.a_i = '0; bus1.b_i = '0; bus1.c_i = 1'b0;

      // Reset then idle.
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset busy_o", 64'(bus4.busy_o), 64'd0);
      chk("reset done_o", 64'(bus4.done_o), 64'd0);
      chk("reset s_o", 64'(bus4.s_o), 64'd0);
      chk("reset c_o", 64'(bus4.c_o), 64'd0);

      // Table-driven single operations.
      for (int i = 0; i < 8; i++) begin
         do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s, vecs[i].co);
      end

      // Held start with operands changed mid-run; then accepted again in DONE.
      @(posedge clk); #1;
      bus4.start_i = 1'b1;
      bus4.a_i = 16'hFFFF; bus4.b_i = 16'hFFFF; bus4.c_i = 1'b1;
      @(posedge clk); #1;
      bus4.a_i = 16'h0001; bus4.b_i = 16'h0001; bus4.c_i = 1'b0;
      wait_done(bc, lat);
      chk("held run1 busy_cycles", 64'(bc), 64'd4);
      chk("held run1 latency", 64'(lat), 64'd4);
      chk("held run1 s_o", 64'(bus4.s_o), 64'h FFFF);
      chk("held run1 c_o", 64'(bus4.c_o), 64'd1);
      @(posedge clk); #1;
      bus4.start_i = 1'b0;
      chk("held run2 busy_o", 64'(bus4.busy_o), 64'd1);
      chk("held run2 s_o cleared", 64'(bus4.s_o), 64'd0);
      wait_done(bc, lat);
      chk("held run2 latency", 64'(lat), 64'd4);
      chk("held run2 s_o", 64'(bus4.s_o), 64'h0002);
      chk("held run2 c_o", 64'(bus4.c_o), 64'd0);

      // Reset asserted on E2 aborts the run.
      @(posedge clk); #1;
      bus4.start_i = 1'b1;
      bus4.a_i = 16'h00FF; bus4.b_i = 16'h0001; bus4.c_i = 1'b0;
      @(posedge clk); #1;
      bus4.start_i = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort busy_o", 64'(bus4.busy_o), 64'd0);
      chk("abort done_o", 64'(bus4.done_o), 64'd0);
      chk("abort s_o", 64'(bus4.s_o), 64'd0);
      chk("abort c_o", 64'(bus4.c_o), 64'd0);
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus4.done_o === 1'b1) ndone++;
      end
      chk("abort no done", 64'(ndone), 64'd0);
      do_op("after abort", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);

      // Single-nibble instance.
      @(posedge clk); #1;
      bus1.start_i = 1'b1;
      bus1.a_i = 4'hF; bus1.b_i = 4'h1; bus1.c_i = 1'b1;
      @(posedge clk); #1;
      bus1.start_i = 1'b0;
      bus1.a_i = 4'h0; bus1.b_i = 4'h0; bus1.c_i = 1'b0;
      @(negedge clk);
      chk("n1 busy_o", 64'(bus1.busy_o), 64'd1);
      chk("n1 early done_o", 64'(bus1.done_o), 64'd0);
      @(negedge clk);
      chk("n1 done_o", 64'(bus1.done_o), 64'd1);
      chk("n1 s_o", 64'(bus1.s_o), 64'h1);
      chk("n1 c_o", 64'(bus1.c_o), 64'd1);
      @(negedge clk);
      chk("n1 done_pulse_end", 64'(bus1.done_o), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/ripple_carry_seq.md
# ripple_carry_seq

Nibble-serial multi-word adder controller built around one instance of the 4-bit `ripple_carry` adder. It accepts two NIBBLES×4-bit operands and a carry-in, then drives the shared adder once per clock, least-significant nibble first. Between nibbles it registers the carry and collects the sum nibbles into a result register. It sits between a requesting datapath and the combinational adder, so a wide addition costs one adder plus a small FSM.

## Interface
- NIBBLES, 4, operand width in nibbles (legal 1..16); operand width W = 4*NIBBLES
- clk_i  input  1  single clock, all state updates on rising edge
- rst_i  input  1  reset, synchronous, active-high
- start_i  input  1  request; sampled only when ready (state IDLE or DONE)
- a_i  input  W  operand A, captured on the accepting edge
- b_i  input  W  operand B, captured on the accepting edge
- c_i  input  1  carry-in, captured on the accepting edge
- busy_o  output  1  high while state RUN
- done_o  output  1  one-cycle pulse: result valid
- s_o  output  W  sum; valid from done_o until next accepted start
- c_o  output  1  carry-out of the MSB nibble; same validity as s_o

## Operation
- Internal registers: a_q, b_q (W), cy_q (1), cnt_q (ceil(log2(NIBBLES)) bits, min 1), s_q (W) drives s_o, co_q drives c_o.
- One `ripple_carry` instance: a_i = a_q[4*cnt_q +: 4], b_i = b_q[4*cnt_q +: 4], c_i = cy_q.
- FSM states IDLE, RUN, DONE. Reset value: IDLE.
- IDLE: start_i=1 -> capture a_i, b_i, c_i into a_q, b_q, cy_q; cnt_q<=0; s_q<=0; co_q<=0; go RUN. Otherwise stay.
- RUN, each edge:
  - s_q[4*cnt_q +: 4] <= adder sum; cy_q <= adder carry-out.
  - If cnt_q == NIBBLES-1: co_q <= adder carry-out; go DONE.
  - Otherwise cnt_q <= cnt_q+1.
- DONE: done_o=1 for exactly this cycle.
  - start_i=1 -> accept new operands, same as in IDLE; go RUN back-to-back.
  - Otherwise go IDLE.
- start_i while RUN is ignored; no queuing; no error flag.
- Operands a_i/b_i/c_i may change freely after the accepting edge.
- Arithmetic: {c_o, s_o} = a + b + c_i modulo 2^(W+1), exact, unsigned.

## Timing
- Reset (rst_i=1 at an edge), from any state including mid-RUN: state IDLE, busy_o=0, done_o=0, s_o=0, c_o=0, cnt_q=0, cy_q=0. An in-flight operation is discarded with no done pulse.
- Reset has priority over start_i on the same edge.
- Accepting edge E0. Nibble k is committed on edge E(k+1). The final nibble is committed on edge E(NIBBLES).
- done_o is high for the cycle after E(NIBBLES). Latency start-to-done = NIBBLES cycles.
- busy_o is high for cycles E0..E(NIBBLES)-1, i.e. NIBBLES cycles.
- Back-to-back throughput: one result per NIBBLES+1 cycles.
- NIBBLES=1: RUN lasts one cycle; done_o is high in the cycle after E1.
- Combinational outputs: busy_o and done_o are decoded from state only. There is no path from start_i to any output.
- During RUN, s_o shows partial sums. The upper nibbles are 0 until written.

## Test plan
- Reset, then idle for 3 cycles -> busy_o=0, done_o=0, s_o=0x0000, c_o=0.
- NIBBLES=4, start with a=0x1234, b=0x4321, c=1 -> busy_o high 4 cycles, then done_o pulse; s_o=0x5556, c_o=0.
- a=0xFFFF, b=0x0001, c=0 -> carry ripples through every nibble; s_o=0x0000, c_o=1, done_o 4 cycles after start.
- a=0xFFFF, b=0xFFFF, c=1, with start_i held high and operands changed to 0x0001/0x0001/0 during RUN -> mid-RUN start and changes ignored; s_o=0xFFFF, c_o=1. The held start_i is then accepted in DONE, giving a new run; s_o=0x0002, c_o=0 after 4 more cycles.
- Start 0x00FF+0x0001, assert rst_i on edge E2 -> no done_o pulse; s_o=0, c_o=0, busy_o=0. A fresh start afterwards completes normally.
- NIBBLES=1 build, a=0xF, b=0x1, c=1 -> done_o 1 cycle after start; s_o=0x1, c_o=1.
